// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter and register scoreboard for the register bank write port.
// Merges a single-cycle ALU result stream (always accepted, highest priority) with a
// FIFO-buffered slow-path (load/multiply) stream into one registered write per cycle,
// and tracks which architectural registers still have a result in flight.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data    ALU result, no backpressure
//   mem_valid/mem_ready/mem_rd/mem_data  slow-path result, valid/ready handshake
//   iss_valid/iss_rd             decode issued a producer of iss_rd
//   busy                         scoreboard, bit r set while a write to xr is pending
//   regWrite/a3/wd3              registered write port to the register bank
//   x0_err                       one-cycle pulse when a write to x0 is dropped
//   fifo_count                   slow-path FIFO occupancy
module wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [XLEN-1:0]          mem_data,
    input  logic                     iss_valid,
    input  logic [4:0]               iss_rd,
    output logic [31:0]              busy,
    output logic                     regWrite,
    output logic [4:0]               a3,
    output logic [XLEN-1:0]          wd3,
    output logic                     x0_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_ent_t;

    wb_ent_t         fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     busy_q;
    logic [31:0]     busy_nxt;

    logic            push;
    logic            pop;
    logic            sel_valid;
    wb_ent_t         sel_ent;

    // Ready depends only on stored occupancy: a full FIFO refuses even while popping.
    assign mem_ready  = (count_q != CW'(DEPTH));
    assign push       = mem_valid && mem_ready;
    assign fifo_count = count_q;
    assign busy       = busy_q;

    // Source selection: ALU first, then FIFO head.
    always_comb begin
        sel_valid = 1'b0;
        sel_ent   = '0;
        pop       = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_ent   = '{rd: alu_rd, data: alu_data};
        end else if (count_q != '0) begin
            sel_valid = 1'b1;
            sel_ent   = fifo_mem[rd_ptr_q];
            pop       = 1'b1;
        end
    end

    // Scoreboard: clear on commit, then set on issue so a newer producer wins.
    always_comb begin
        busy_nxt = busy_q;
        if (sel_valid && (sel_ent.rd != 5'd0)) begin
            busy_nxt[sel_ent.rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // FIFO storage, no reset needed: validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{rd: mem_rd, data: mem_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered write port, x0 drop pulse and scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite <= 1'b0;
            a3       <= '0;
            wd3      <= '0;
            x0_err   <= 1'b0;
            busy_q   <= '0;
        end else begin
            regWrite <= sel_valid && (sel_ent.rd != 5'd0);
            x0_err   <= sel_valid && (sel_ent.rd == 5'd0);
            if (sel_valid && (sel_ent.rd != 5'd0)) begin
                a3  <= sel_ent.rd;
                wd3 <= sel_ent.data;
            end
            busy_q <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios followed by randomized traffic, all
// checked against a queue-based reference model of the writeback/scoreboard rules.
module tb_wb_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [4:0]        mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              iss_valid;
    logic [4:0]        iss_rd;
    logic [31:0]       busy;
    logic              regWrite;
    logic [4:0]        a3;
    logic [XLEN-1:0]   wd3;
    logic              x0_err;
    logic [CW-1:0]     fifo_count;

    wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .busy       (busy),
        .regWrite   (regWrite),
        .a3         (a3),
        .wd3        (wd3),
        .x0_err     (x0_err),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            q[$];
    logic [31:0]     m_busy;
    logic            m_rw;
    logic            m_x0;
    logic [4:0]      m_a3;
    logic [XLEN-1:0] m_wd3;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".regWrite"},   64'(regWrite),   64'(m_rw));
        check({tag, ".x0_err"},     64'(x0_err),     64'(m_x0));
        check({tag, ".a3"},         64'(a3),         64'(m_a3));
        check({tag, ".wd3"},        64'(wd3),        64'(m_wd3));
        check({tag, ".busy"},       64'(busy),       64'(m_busy));
        check({tag, ".fifo_count"}, 64'(fifo_count), 64'(q.size()));
        check({tag, ".mem_ready"},  64'(mem_ready),  64'(q.size() != DEPTH));
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = '0;
        m_rw   = 1'b0;
        m_x0   = 1'b0;
        m_a3   = '0;
        m_wd3  = '0;
    endtask

    // Drive one cycle of inputs (called at a falling edge), advance the model for the
    // coming rising edge, then check all outputs at the next falling edge.
    task automatic step(input string tag,
                        input logic av, input logic [4:0] ard, input logic [XLEN-1:0] adata,
                        input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] mdata,
                        input logic iv, input logic [4:0] ird);
        bit   rdy;
        bit   sv;
        ent_t s;
        alu_valid = av;  alu_rd = ard;  alu_data = adata;
        mem_valid = mv;  mem_rd = mrd;  mem_data = mdata;
        iss_valid = iv;  iss_rd = ird;
        rdy = (q.size() != DEPTH);
        sv  = 1'b0;
        s.rd = '0; s.data = '0;
        if (av) begin
            s.rd = ard; s.data = adata; sv = 1'b1;
        end else if (q.size() > 0) begin
            s = q.pop_front(); sv = 1'b1;
        end
        if (mv && rdy) q.push_back('{mrd, mdata});
        m_rw = sv && (s.rd != 0);
        m_x0 = sv && (s.rd == 0);
        if (m_rw) begin
            m_a3 = s.rd; m_wd3 = s.data; m_busy[s.rd] = 1'b0;
        end
        if (iv && ird != 0) m_busy[ird] = 1'b1;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        iss_valid = 0; iss_rd = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all("reset");

        // ALU write and one-cycle regWrite
        step("alu", 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        check("alu_a3", 64'(a3), 64'd5);
        check("alu_wd3", 64'(wd3), 64'hDEADBEEF);
        idle("alu_after");
        check("alu_rw_low", 64'(regWrite), 64'd0);

        // Priority: ALU commits first, queued mem commits next cycle
        step("prio0", 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 0);
        check("prio_a3_first", 64'(a3), 64'd3);
        check("prio_cnt1", 64'(fifo_count), 64'd1);
        idle("prio1");
        check("prio_a3_second", 64'(a3), 64'd4);
        check("prio_cnt0", 64'(fifo_count), 64'd0);

        // Fill FIFO under continuous ALU traffic, then drain in order
        for (int i = 0; i < 4; i++)
            step("fill", 1, 5'd1, 32'(i), 1, 5'(8 + i), 32'(32'h100 + i), 0, 0);
        check("full_ready", 64'(mem_ready), 64'd0);
        check("full_cnt", 64'(fifo_count), 64'd4);
        // offer a fifth entry while full: must be refused even though a pop happens
        step("drain0", 0, 0, 0, 1, 5'd20, 32'hBAD, 0, 0);
        check("drain_a3_0", 64'(a3), 64'd8);
        check("drain_ready", 64'(mem_ready), 64'd1);
        for (int i = 1; i < 4; i++) begin
            idle("drain");
            check("drain_a3", 64'(a3), 64'(8 + i));
        end
        idle("drain_end");
        check("drain_empty", 64'(fifo_count), 64'd0);

        // x0: write dropped, pulse, a3/wd3 hold, issue of x0 ignored
        step("x0", 1, 5'd0, 32'h5, 0, 0, 0, 1, 5'd0);
        check("x0_pulse", 64'(x0_err), 64'd1);
        check("x0_hold_a3", 64'(a3), 64'd11);
        check("x0_busy", 64'(busy), 64'd0);
        idle("x0_after");
        check("x0_pulse_end", 64'(x0_err), 64'd0);

        // Scoreboard set/clear, set wins on collision
        step("sb_set", 0, 0, 0, 0, 0, 0, 1, 5'd7);
        check("sb_b7_set", 64'(busy[7]), 64'd1);
        step("sb_both", 1, 5'd7, 32'h77, 0, 0, 0, 1, 5'd7);
        check("sb_b7_kept", 64'(busy[7]), 64'd1);
        step("sb_clr", 1, 5'd7, 32'h78, 0, 0, 0, 0, 0);
        check("sb_b7_clr", 64'(busy[7]), 64'd0);

        // Reset mid-operation with queued entries and pending busy bits
        for (int i = 0; i < 4; i++)
            step("pre_rst", 1, 5'd1, 32'h0, (i < 3), 5'(12 + i), 32'(i), 1, 5'(8 + i));
        check("pre_rst_cnt", 64'(fifo_count), 64'd3);
        check("pre_rst_busy", 64'(busy), 64'h0000_0F00);
        alu_valid = 0; mem_valid = 0; iss_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_cnt", 64'(fifo_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rw", 64'(regWrite), 64'd0);
        check("rst_ready", 64'(mem_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all("rst_rel");
        for (int i = 0; i < 4; i++) idle("post_rst");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic av, mv, iv;
            logic [4:0] ard, mrd, ird;
            av  = ($urandom_range(0, 99) < 40);
            mv  = ($urandom_range(0, 99) < 60);
            iv  = ($urandom_range(0, 99) < 50);
            ard = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ird = 5'($urandom_range(0, 31));
            step("rand", av, ard, 32'($urandom), mv, mrd, 32'($urandom), iv, ird);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and scoreboard driving the register bank's single write port. It merges a single-cycle ALU result stream with a buffered multi-cycle (load/multiply) result stream into one registered `regWrite`/`a3`/`wd3` write per cycle. It also tracks which architectural registers have a result in flight. The block sits between the execute/memory stages and the register bank; decode reads its `busy` vector for hazard stalls.

## Interface
- `DEPTH`, 4: slow-path FIFO entries; power of two, ≥2.
- `XLEN`, 32: data width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result present this cycle; always accepted, no ready.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `mem_valid`  in  1  slow-path result offered.
- `mem_ready`  out  1  slow-path FIFO can accept; transfer when `mem_valid && mem_ready` at a rising edge.
- `mem_rd`  in  5  slow-path destination register.
- `mem_data`  in  XLEN  slow-path result.
- `iss_valid`  in  1  decode issued an instruction that will write `iss_rd`.
- `iss_rd`  in  5  issued destination register.
- `busy`  out  32  scoreboard; bit r=1 means a write to xr is pending.
- `regWrite`  out  1  write enable to register bank (registered).
- `a3`  out  5  write address (registered).
- `wd3`  out  XLEN  write data (registered).
- `x0_err`  out  1  one-cycle pulse: a write to x0 was dropped.
- `fifo_count`  out  clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Slow path: circular FIFO with read/write pointers and an occupancy counter. The pointers wrap modulo DEPTH. `mem_ready = (fifo_count != DEPTH)`, so a full FIFO refuses a push even if it pops in the same cycle.
- Selection each cycle: `alu_valid` wins. Otherwise, if the FIFO is non-empty, its head is popped. Otherwise nothing is selected.
- There is no starvation guard: continuous `alu_valid` holds the FIFO. The upstream pipeline guarantees gaps.
- Selected entry with rd≠0: at the edge, `regWrite`←1, `a3`←rd, `wd3`←data.
- Selected entry with rd=0: the entry is consumed. `regWrite`←0 and `x0_err`←1 for one cycle; `a3`/`wd3` hold their previous values.
- No entry selected: `regWrite`←0 and `x0_err`←0; `a3`/`wd3` hold.
- Same-cycle push and pop when not full: both occur, and `fifo_count` is unchanged.
- Scoreboard set: `busy[iss_rd]`←1 when `iss_valid` and `iss_rd`≠0.
- Scoreboard clear: `busy[rd]`←0 when an entry with rd≠0 is selected.
- Set and clear of the same register at one edge: set wins, because a newer producer was issued.
- `busy[0]` is constant 0.
- Writes for a register whose busy bit is already 0 are still performed; the bit stays 0.

## Timing
- Reset (async assert, sync-safe deassert): `regWrite`=0, `a3`=0, `wd3`=0, `x0_err`=0, `busy`=0, FIFO empty, `fifo_count`=0, `mem_ready`=1. Reset mid-operation discards all queued entries and pending busy bits.
- ALU latency: `alu_valid` sampled at edge E → `regWrite` high in the cycle following E. The register bank commits at E+1.
- Slow-path minimum latency: push at edge E → pop at E+1 (if no ALU) → `regWrite` high during the cycle after E+1. No bypass around the FIFO.
- `regWrite` is high for exactly one cycle per committed entry. Back-to-back commits are allowed every cycle.
- `mem_ready` and `busy` are combinational from registered state only, with no input-to-output paths.
- Throughput: one commit per cycle total. FIFO sustained input rate equals the cycles without `alu_valid`.

## Test plan
- Reset then ALU write: `alu_valid`=1, `alu_rd`=5, `alu_data`=0xDEADBEEF for 1 cycle → next cycle `regWrite`=1, `a3`=5, `wd3`=0xDEADBEEF; following cycle `regWrite`=0.
- Priority and queuing: same cycle `alu_valid` (rd=3, data=0x11) and `mem_valid` (rd=4, data=0x22) → commit x3 first, then x4 one cycle later; `fifo_count` goes 1→0.
- Full FIFO: hold `alu_valid`=1 (rd=1) while pushing mem rd=8..11 → after 4 pushes `mem_ready`=0 and `fifo_count`=4. Drop `alu_valid` → x8, x9, x10, x11 commit in order on consecutive cycles, and `mem_ready` returns to 1 after the first pop.
- x0 handling: ALU rd=0, data=0x5 → `regWrite` stays 0, `x0_err` pulses 1 cycle, `a3`/`wd3` unchanged; `iss_valid` with rd=0 leaves `busy`=0.
- Scoreboard: issue rd=7 → `busy[7]`=1. In the same cycle issue rd=7 again and commit rd=7 → `busy[7]` stays 1. A later commit rd=7 → `busy[7]`=0.
- Reset mid-operation: 3 entries queued and `busy`=0x00000F00 → assert `rst_n`=0 asynchronously → `fifo_count`=0, `busy`=0, `regWrite`=0 immediately; no stale commits after release.
